// File: rtl/apb_reg_slave_if.sv
// APB bus bundle between a master and apb_reg_slave.
// The clock, the reset and the PCLKEN clock enable are plain module ports.
interface apb_reg_slave_if #(
  parameter int ADDRWIDTH = 16,
  parameter int DATAWIDTH = 32
);
  logic                 PSEL;
  logic                 PENABLE;
  logic                 PWRITE;
  logic [ADDRWIDTH-1:0] PADDR;
  logic [DATAWIDTH-1:0] PWDATA;
  logic [3:0]           PSTRB;
  logic [DATAWIDTH-1:0] PRDATA;
  logic                 PREADY;
  logic                 PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_reg_slave.sv
// APB register slave.
// It provides NUM_REGS read/write registers with byte strobes, a constant ID
// register and a counter of completed transfers (XCNT).
// Each access is held for WAIT_CYCLES wait states, and state advances only on
// HCLK edges with PCLKEN=1.
module apb_reg_slave #(
  parameter int          ADDRWIDTH   = 16,
  parameter int          DATAWIDTH   = 32,
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  PCLKEN,
  apb_reg_slave_if.slave        apb
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    CHECK  = 2'b10
  } state_e;

  // Decode limits are 7 bits wide so that NUM_REGS+1 fits even when NUM_REGS is 64.
  localparam logic [6:0] ID_IDX   = 7'(NUM_REGS);
  localparam logic [6:0] XCNT_IDX = 7'(NUM_REGS + 1);
  localparam logic [3:0] WAIT_LD  = 4'(WAIT_CYCLES);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q,   cnt_d;
  logic [5:0]    idx_q,   idx_d;
  logic          wr_q,    wr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    strb_q,  strb_d;
  logic [31:0]   xcnt_q,  xcnt_d;
  logic [31:0]   regs_q [NUM_REGS];
  logic [31:0]   regs_d [NUM_REGS];

  logic [6:0]    idx_ext_s;
  logic          is_reg_s;
  logic          is_id_s;
  logic          is_xcnt_s;
  logic          err_s;
  logic          pready_s;
  logic          setup_s;
  logic          complete_s;
  logic          commit_s;
  logic [31:0]   rd_val_s;
  logic          unused_paddr_s;

  // Only PADDR[7:2] selects a register; the other address bits alias.
  assign unused_paddr_s = ^apb.PADDR;

  // Decode the latched index and classify the access.
  always_comb begin
    idx_ext_s = {1'b0, idx_q};
    is_reg_s  = (idx_ext_s < ID_IDX);
    is_id_s   = (idx_ext_s == ID_IDX);
    is_xcnt_s = (idx_ext_s == XCNT_IDX);
    err_s     = (wr_q && (is_id_s || is_xcnt_s)) || !(is_reg_s || is_id_s || is_xcnt_s);
  end

  // Bus events. Every event requires an enabled APB cycle.
  always_comb begin
    pready_s   = (state_q == ACCESS) && (cnt_q == 4'd0);
    setup_s    = PCLKEN && (state_q == IDLE) && apb.PSEL && !apb.PENABLE;
    complete_s = PCLKEN && (state_q == ACCESS) && apb.PSEL && apb.PENABLE && pready_s;
    commit_s   = complete_s && wr_q && is_reg_s;
  end

  // Next-state logic. CHECK and any illegal encoding fall back to IDLE at once.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (setup_s) begin
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (PCLKEN && !apb.PSEL) begin
          state_d = IDLE;
        end else if (complete_s) begin
          state_d = IDLE;
        end else begin
          state_d = ACCESS;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Latch the request at setup, then count wait states down on enabled cycles.
  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    if (setup_s) begin
      cnt_d   = WAIT_LD;
      idx_d   = apb.PADDR[7:2];
      wr_d    = apb.PWRITE;
      wdata_d = apb.PWDATA[31:0];
      strb_d  = apb.PSTRB;
    end else if (PCLKEN && (state_q == ACCESS) && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // The transfer counter wraps naturally at 32 bits.
  // It also counts completions that return an error.
  always_comb begin
    if (complete_s) begin
      xcnt_d = xcnt_q + 32'd1;
    end else begin
      xcnt_d = xcnt_q;
    end
  end

  // On a write completion, update only the byte lanes enabled by the strobes.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (commit_s && (idx_ext_s == 7'(i))) begin
        for (int b = 0; b < 4; b++) begin
          if (strb_q[b]) begin
            regs_d[i][8*b +: 8] = wdata_q[8*b +: 8];
          end else begin
            regs_d[i][8*b +: 8] = regs_q[i][8*b +: 8];
          end
        end
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Read mux. An unmapped index reads as zero.
  always_comb begin
    rd_val_s = 32'h0000_0000;
    if (is_id_s) begin
      rd_val_s = ID_VALUE;
    end else if (is_xcnt_s) begin
      rd_val_s = xcnt_q;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (idx_ext_s == 7'(i)) begin
          rd_val_s = regs_q[i];
        end else begin
          rd_val_s = rd_val_s;
        end
      end
    end
  end

  // Responses are combinational and held at zero outside the ready cycle.
  always_comb begin
    apb.PREADY  = pready_s;
    apb.PSLVERR = pready_s && err_s;
    if (pready_s && !wr_q) begin
      apb.PRDATA = DATAWIDTH'(rd_val_s);
    end else begin
      apb.PRDATA = '0;
    end
  end

  // FSM state register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latched request fields and the wait-state counter.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_q   <= 4'd0;
      idx_q   <= 6'd0;
      wr_q    <= 1'b0;
      wdata_q <= 32'h0000_0000;
      strb_q  <= 4'b0000;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
    end
  end

  // Register file and the transfer counter.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      xcnt_q <= 32'h0000_0000;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 32'h0000_0000;
      end
    end else begin
      xcnt_q <= xcnt_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed self-checking bench for apb_reg_slave with the default parameters.
// These are NUM_REGS=8 and WAIT_CYCLES=2, so ID is at idx 8 and XCNT at idx 9.
`timescale 1ns/1ps
module tb_apb_reg_slave;

  logic clk;
  logic rstn;
  logic pclken;
  logic div_mode;
  int   div_cnt;
  int   n_checks;
  int   n_fail;
  logic [31:0] xcnt_exp;

  apb_reg_slave_if #(.ADDRWIDTH(16), .DATAWIDTH(32)) bus ();

  apb_reg_slave #(
    .ADDRWIDTH(16), .DATAWIDTH(32), .NUM_REGS(8), .WAIT_CYCLES(2), .ID_VALUE(32'hA5B0_0001)
  ) dut (
    .HCLK(clk),
    .HRESETn(rstn),
    .PCLKEN(pclken),
    .apb(bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // PCLKEN is either always high or high on every third HCLK edge.
  initial begin
    pclken  = 1'b1;
    div_cnt = 0;
    forever begin
      @(negedge clk);
      if (div_mode) begin
        div_cnt = (div_cnt == 2) ? 0 : div_cnt + 1;
        pclken  = (div_cnt == 0);
      end else begin
        pclken = 1'b1;
      end
    end
  end

  // Safety net in case something hangs outside a bounded loop.
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic wait_en_edge();
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      if (pclken) break;
    end
  endtask

  // One complete APB transfer.
  // waits counts the enabled cycles with PREADY low.
  // leak flags a nonzero PRDATA or PSLVERR seen before PREADY.
  task automatic xfer(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, output logic [31:0] rdata, output logic err,
                      output int waits, output logic leak);
    logic done;
    logic s_ready;
    logic s_err;
    logic [31:0] s_data;
    @(negedge clk);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr;
    bus.PADDR = addr; bus.PWDATA = wdata; bus.PSTRB = strb;
    wait_en_edge();
    done = 1'b0; waits = 0; leak = 1'b0;
    s_ready = 1'b0; s_err = 1'b0; s_data = 32'h0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      bus.PENABLE = 1'b1;
      s_ready = bus.PREADY; s_err = bus.PSLVERR; s_data = bus.PRDATA;
      if (!s_ready && (s_data !== 32'h0 || s_err !== 1'b0)) leak = 1'b1;
      @(posedge clk);
      if (pclken) begin
        if (s_ready) done = 1'b1;
        else waits++;
      end
    end
    rdata = s_data; err = s_err;
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL xfer_timeout addr=%h: PREADY never seen, required within 100 cycles", addr);
    end
  endtask

  task automatic bus_idle();
    @(negedge clk);
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    bus.PADDR = 16'h0; bus.PWDATA = 32'h0; bus.PSTRB = 4'h0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.PREADY !== 1'b0) begin n_fail++; $display("FAIL rst_pready got=%b exp=0", bus.PREADY); end
    n_checks++; if (bus.PSLVERR !== 1'b0) begin n_fail++; $display("FAIL rst_pslverr got=%b exp=0", bus.PSLVERR); end
    n_checks++; if (bus.PRDATA !== 32'h0) begin n_fail++; $display("FAIL rst_prdata got=%h exp=0", bus.PRDATA); end
    rstn = 1'b1;
    xcnt_exp = 32'h0;
  endtask

  task automatic test_basic();
    logic [31:0] rd; logic err; int w; logic lk;
    xfer(1'b1, 16'h0000, 32'h1234_5678, 4'b1111, rd, err, w, lk); xcnt_exp++;
    n_checks++; if (w !== 2) begin n_fail++; $display("FAIL wr0_waits got=%0d exp=2", w); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL wr0_err got=%b exp=0", err); end
    xfer(1'b0, 16'h0000, 32'h0, 4'b0000, rd, err, w, lk); xcnt_exp++;
    n_checks++; if (rd !== 32'h1234_5678) begin n_fail++; $display("FAIL rd0_data got=%h exp=12345678", rd); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rd0_err got=%b exp=0", err); end
    n_checks++; if (w !== 2) begin n_fail++; $display("FAIL rd0_waits got=%0d exp=2", w); end
    n_checks++; if (lk !== 1'b0) begin n_fail++; $display("FAIL rd0_early_data got=%b exp=0", lk); end
    xfer(1'b1, 16'h0004, 32'hFFFF_FFFF, 4'b0101, rd, err, w, lk); xcnt_exp++;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL wr1_err got=%b exp=0", err); end
    xfer(1'b0, 16'h0024, 32'h0, 4'b0000, rd, err, w, lk);
    n_checks++; if (rd !== 32'd3) begin n_fail++; $display("FAIL xcnt_after3 got=%h exp=3", rd); end
    xcnt_exp++;
    xfer(1'b0, 16'h0004, 32'h0, 4'b0000, rd, err, w, lk); xcnt_exp++;
    n_checks++; if (rd !== 32'h00FF_00FF) begin n_fail++; $display("FAIL rd1_strobe got=%h exp=00ff00ff", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err; int w; logic lk;
    xfer(1'b1, 16'h0020, 32'hDEAD_BEEF, 4'b1111, rd, err, w, lk); xcnt_exp++;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL wr_id_err got=%b exp=1", err); end
    xfer(1'b0, 16'h0020, 32'h0, 4'b0000, rd, err, w, lk); xcnt_exp++;
    n_checks++; if (rd !== 32'hA5B0_0001) begin n_fail++; $display("FAIL rd_id got=%h exp=a5b00001", rd); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rd_id_err got=%b exp=0", err); end
    xfer(1'b0, 16'h0034, 32'h0, 4'b0000, rd, err, w, lk); xcnt_exp++;
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rd_unmapped_data got=%h exp=0", rd); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL rd_unmapped_err got=%b exp=1", err); end
    xfer(1'b1, 16'h0000, 32'hFFFF_FFFF, 4'b0000, rd, err, w, lk); xcnt_exp++;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL wr_nostrb_err got=%b exp=0", err); end
    xfer(1'b0, 16'h0000, 32'h0, 4'b0000, rd, err, w, lk); xcnt_exp++;
    n_checks++; if (rd !== 32'h1234_5678) begin n_fail++; $display("FAIL rd0_after_nostrb got=%h exp=12345678", rd); end
    xfer(1'b1, 16'h0024, 32'h0, 4'b1111, rd, err, w, lk); xcnt_exp++;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL wr_xcnt_err got=%b exp=1", err); end
    xfer(1'b0, 16'h0024, 32'h0, 4'b0000, rd, err, w, lk);
    n_checks++; if (rd !== xcnt_exp) begin n_fail++; $display("FAIL xcnt_after_err got=%h exp=%h", rd, xcnt_exp); end
    xcnt_exp++;
  endtask

  task automatic test_alias();
    logic [31:0] rd; logic err; int w; logic lk;
    xfer(1'b1, 16'hFF08, 32'hCAFE_BABE, 4'b1111, rd, err, w, lk); xcnt_exp++;
    xfer(1'b0, 16'h000B, 32'h0, 4'b0000, rd, err, w, lk); xcnt_exp++;
    n_checks++; if (rd !== 32'hCAFE_BABE) begin n_fail++; $display("FAIL alias_rd got=%h exp=cafebabe", rd); end
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic err; int w; logic lk;
    bus_idle();
    @(negedge clk);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
    bus.PADDR = 16'h000C; bus.PWDATA = 32'h5A5A_5A5A; bus.PSTRB = 4'b1111;
    wait_en_edge();
    @(negedge clk);
    bus.PSEL = 1'b0; bus.PENABLE = 1'b1;
    repeat (4) @(negedge clk);
    bus.PENABLE = 1'b0;
    xfer(1'b0, 16'h000C, 32'h0, 4'b0000, rd, err, w, lk); xcnt_exp++;
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL abort_nowrite got=%h exp=0", rd); end
    xfer(1'b0, 16'h0024, 32'h0, 4'b0000, rd, err, w, lk);
    n_checks++; if (rd !== xcnt_exp) begin n_fail++; $display("FAIL abort_xcnt got=%h exp=%h", rd, xcnt_exp); end
    xcnt_exp++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic err; int w; logic lk;
    bus_idle();
    div_mode = 1'b1;
    xfer(1'b1, 16'h0010, 32'h1111_1111, 4'b1111, rd, err, w, lk); xcnt_exp++;
    n_checks++; if (w !== 2) begin n_fail++; $display("FAIL b2b_wr4_waits got=%0d exp=2", w); end
    xfer(1'b1, 16'h0014, 32'h2222_2222, 4'b1111, rd, err, w, lk); xcnt_exp++;
    n_checks++; if (w !== 2) begin n_fail++; $display("FAIL b2b_wr5_waits got=%0d exp=2", w); end
    bus_idle();
    div_mode = 1'b0;
    xfer(1'b0, 16'h0010, 32'h0, 4'b0000, rd, err, w, lk); xcnt_exp++;
    n_checks++; if (rd !== 32'h1111_1111) begin n_fail++; $display("FAIL b2b_rd4 got=%h exp=11111111", rd); end
    xfer(1'b0, 16'h0014, 32'h0, 4'b0000, rd, err, w, lk); xcnt_exp++;
    n_checks++; if (rd !== 32'h2222_2222) begin n_fail++; $display("FAIL b2b_rd5 got=%h exp=22222222", rd); end
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] rd; logic err; int w; logic lk;
    logic seen;
    bus_idle();
    @(negedge clk);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
    bus.PADDR = 16'h0018; bus.PWDATA = 32'h7777_7777; bus.PSTRB = 4'b1111;
    wait_en_edge();
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      bus.PENABLE = 1'b1;
      if (bus.PREADY === 1'b1) seen = 1'b1;
      else @(posedge clk);
    end
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got=%b exp=1", seen); end
    rstn = 1'b0;
    #1;
    n_checks++; if (bus.PREADY !== 1'b0) begin n_fail++; $display("FAIL midrst_pready got=%b exp=0", bus.PREADY); end
    n_checks++; if (bus.PSLVERR !== 1'b0) begin n_fail++; $display("FAIL midrst_pslverr got=%b exp=0", bus.PSLVERR); end
    n_checks++; if (bus.PRDATA !== 32'h0) begin n_fail++; $display("FAIL midrst_prdata got=%h exp=0", bus.PRDATA); end
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    xcnt_exp = 32'h0;
    xfer(1'b0, 16'h0018, 32'h0, 4'b0000, rd, err, w, lk); xcnt_exp++;
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL midrst_reg6 got=%h exp=0", rd); end
    xfer(1'b0, 16'h0000, 32'h0, 4'b0000, rd, err, w, lk); xcnt_exp++;
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL midrst_reg0 got=%h exp=0", rd); end
    xfer(1'b0, 16'h0024, 32'h0, 4'b0000, rd, err, w, lk);
    n_checks++; if (rd !== xcnt_exp) begin n_fail++; $display("FAIL midrst_xcnt got=%h exp=%h", rd, xcnt_exp); end
    bus_idle();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    div_mode = 1'b0;
    xcnt_exp = 32'h0;
    test_reset();
    test_basic();
    test_errors();
    test_alias();
    test_abort();
    test_back_to_back();
    test_reset_mid_access();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_reg_slave.md
APB_REG_SLAVE -- requirements
Module: apb_reg_slave

Interface
REQ-001 Parameter ADDRWIDTH, 16, APB address width.
REQ-002 Parameter DATAWIDTH, 32, APB data width; only 32 is supported.
REQ-003 Parameter NUM_REGS, 8, number of read/write registers; legal range 1..64.
REQ-004 Parameter WAIT_CYCLES, 2, wait states inserted per access; legal range 0..15.
REQ-005 Parameter ID_VALUE, 32'hA5B0_0001, constant returned by the ID register.
REQ-006 Reset HRESETn is asynchronous and active-low; clock is HCLK.
REQ-007 Port HCLK, input, 1, clock.
REQ-008 Port HRESETn, input, 1, asynchronous active-low reset.
REQ-009 Port PCLKEN, input, 1, APB clock enable; the APB cycle is the HCLK edge with PCLKEN=1.
REQ-010 Ports PSEL, PENABLE and PWRITE, input, 1 each, APB control.
REQ-011 Port PADDR, input, ADDRWIDTH, byte address; bits [1:0] are ignored.
REQ-012 Port PWDATA, input, DATAWIDTH, write data.
REQ-013 Port PSTRB, input, 4, write byte strobes; bit n enables byte lane n.
REQ-014 Port PRDATA, output, DATAWIDTH, read data.
REQ-015 Port PREADY, output, 1, access complete.
REQ-016 Port PSLVERR, output, 1, error response.

Function
REQ-017 All state SHALL change only on HCLK rising edges with PCLKEN=1; PCLKEN=0 edges SHALL hold all state.
REQ-018 The FSM SHALL have three states: IDLE, ACCESS and CHECK.
  - IDLE -> ACCESS on an APB cycle with PSEL=1 and PENABLE=0 (setup).
  - Other inputs in IDLE SHALL be ignored.
REQ-019 The setup edge SHALL latch:
  - idx = PADDR[7:2];
  - PWRITE, PWDATA and PSTRB;
  - wait counter = WAIT_CYCLES.
REQ-020 In ACCESS, the counter SHALL decrement by 1 on each APB cycle while it is nonzero.
REQ-021 PREADY SHALL be combinational: 1 iff state=ACCESS and counter=0.
  - Exactly WAIT_CYCLES PENABLE-high APB cycles SHALL have PREADY=0.
REQ-022 The completion edge is an APB cycle in ACCESS with PSEL=1, PENABLE=1 and PREADY=1.
  - On it the FSM SHALL return to IDLE.
  - Writes SHALL commit on this edge.
REQ-023 If PSEL=0 on any APB cycle in ACCESS, the FSM SHALL abort to IDLE.
  - On abort: no write, no counter increment, no response.
REQ-024 Address map (idx):
  - 0..NUM_REGS-1: read/write REG[idx];
  - NUM_REGS: read-only ID;
  - NUM_REGS+1: read-only transfer counter XCNT;
  - anything else: unmapped.
REQ-025 A write to REG SHALL update only the byte lanes whose PSTRB bit is 1; PSTRB=0000 SHALL leave the register unchanged with no error.
REQ-026 PSLVERR SHALL equal PREADY AND err, where err is set for:
  - a write to ID or XCNT;
  - any access to an unmapped idx.
REQ-027 An errored access SHALL modify no register.
REQ-028 PRDATA SHALL carry the read value of the latched idx when PREADY=1 and PWRITE=0, and 0 otherwise.
  - Unmapped reads SHALL return 0.
REQ-029 XCNT SHALL increment by 1 on every completion edge, including errored ones.
  - It SHALL wrap from 32'hFFFF_FFFF to 0.
  - A read of XCNT SHALL return the value before its own increment.
REQ-030 Back-to-back transfers SHALL be supported: the setup may occur on the first APB cycle after completion.
REQ-031 PADDR bits above [7:2] SHALL be ignored (address aliasing).
REQ-032 The CHECK state SHALL be unreachable; any illegal state encoding SHALL return to IDLE on the next HCLK edge.

Reset
REQ-033 While HRESETn=0:
  - state = IDLE and counter = 0;
  - all REG = 0 and XCNT = 0;
  - PREADY, PSLVERR and PRDATA = 0.
REQ-034 Reset asserted mid-access SHALL abandon the transfer with no write.
REQ-035 The first setup may occur on the first PCLKEN edge after deassertion.

Verification
REQ-036 Write idx 0 with 32'h1234_5678 and PSTRB=1111, WAIT_CYCLES=2 -> PREADY low for 2 enable cycles, then high; read idx 0 -> 32'h1234_5678, PSLVERR=0.
REQ-037 Write 32'hFFFF_FFFF to REG1 (which holds 0) with PSTRB=0101 -> REG1 reads 32'h00FF_00FF.
REQ-038 Write ID -> PSLVERR=1 with PREADY, ID unchanged; read idx NUM_REGS+5 -> PRDATA=0, PSLVERR=1.
REQ-039 Three completed transfers after reset, then read XCNT -> 3; PSEL dropped mid-ACCESS -> no write, and XCNT unchanged.
REQ-040 PCLKEN=1 every third HCLK with back-to-back writes -> counting occurs only on enabled edges and both writes commit; HRESETn pulsed during ACCESS -> all outputs 0 and REG unchanged from its pre-write value.
